wm_phase_timer: RTL and testbench
=================================

// Module: wm_phase_timer
// PURPOSE
//  Timing and sensing front end for the washing-machine controller FSM. Watches the
//  controller's 3-bit state, times each timed phase (wash/rinse/spin/drain) with a
//  prescaled tick counter, and returns a one-cycle cycle_complete pulse to the FSM.
//  Also debounces the raw water-level sensor into water_level and flags fill timeout.
// PARAMETERS
//  CLK_DIV      1000  clk cycles per timer tick (>=1)
//  CNT_W        16    width of tick counters / remaining output
//  WASH_TICKS   30    ticks in wash phase (state 3'b010)
//  RINSE_TICKS  20    ticks in rinse phase (3'b011)
//  SPIN_TICKS   15    ticks in spin phase (3'b100)
//  DRAIN_TICKS  10    ticks in drain phase (3'b101)
//  FILL_TMO     50    ticks allowed in fill (3'b001) before fill_timeout
//  DEB_CYCLES   8     consecutive equal synced samples to change water_level (>=1)
// PORTS
//  clk             in   1      clock
//  rst             in   1      reset, asynchronous, active-low
//  state           in   3      controller state: 0 idle,1 fill,2 wash,3 rinse,4 spin,5 drain,6 end,7 error
//  door_closed     in   1      door switch, synchronous to clk
//  water_level_raw in   1      raw level sensor, asynchronous, bouncy
//  cycle_complete  out  1      registered 1-cycle pulse: current timed phase finished
//  water_level     out  1      debounced level, registered
//  fill_timeout    out  1      sticky while in fill after FILL_TMO ticks without water_level
//  busy            out  1      timer in RUN
//  remaining       out  CNT_W  ticks left in current timed phase; 0 otherwise
// BEHAVIOUR
//  Reset: all outputs 0; phase_q=0 (idle), presc=0, timer state IDLE, sync/debounce regs 0.
//  Timer states: IDLE (untimed phase), RUN, PAUSE, DONE.
//  Phase change: cycle 0 = first cycle with state!=phase_q. On edge ending cycle 0:
//   phase_q<=state, presc<=0, remaining<=duration(state) (0 for untimed), fill tick cnt<=0,
//   fill_timeout<=0; timer->RUN if timed, else IDLE. Any pending pulse is dropped (change wins).
//  Prescaler: in RUN presc counts 0..CLK_DIV-1, wraps; tick = RUN && presc==CLK_DIV-1.
//   In fill phase presc runs likewise to drive fill tick counter.
//  RUN: on tick remaining decrements. On tick with remaining==1: cycle_complete<=1, ->DONE.
//   Duration 0: cycle_complete<=1 on the load edge, ->DONE (pulse in cycle 1).
//   Latency: pulse high in cycle DUR*CLK_DIV+1 after cycle 0, exactly one cycle.
//  DONE: cycle_complete cleared next cycle; no further pulses until phase changes.
//  PAUSE: RUN && !door_closed -> PAUSE; presc and remaining frozen, no tick.
//   PAUSE && door_closed -> RUN, counting resumes from frozen values.
//  Untimed phases (idle/fill/end/error): remaining=0, cycle_complete never asserted.
//  Water level: 2-flop synchronizer, then counter; water_level toggles after DEB_CYCLES
//   consecutive synced samples differing from it; any equal sample clears counter.
//   Latency from clean raw edge: DEB_CYCLES+2 cycles.
//  Fill timeout: in fill, fill ticks count while water_level==0; reaching FILL_TMO sets
//   fill_timeout (held until phase leaves fill); water_level==1 clears fill tick count.
//  Widths: durations and FILL_TMO must fit CNT_W; counters saturate, never wrap.
//  Reset mid-phase: everything returns to reset values immediately; no pulse.
// TESTING
//  CLK_DIV=4, WASH_TICKS=3: state 1->2 at cycle 0, door closed -> single cycle_complete in cycle 13.
//  Same, door_closed low cycles 5-9 -> pulse delayed 5 cycles to cycle 18; remaining frozen.
//  Wash running, state 2->7 at cycle 6 -> no pulse ever; remaining=0, busy=0 from cycle 1 after.
//  DRAIN_TICKS=0: state ->5 -> cycle_complete high only in cycle 1.
//  DEB_CYCLES=8: raw glitch 5 cycles -> water_level stays 0; raw high 20 cycles -> rises at cycle 10.
//  Fill, FILL_TMO=2, CLK_DIV=4, level low -> fill_timeout=1 from cycle 9; ->wash clears it.

Source files
------------

// File: rtl/wm_phase_timer_if.sv
// Signal bundle between the washing-machine controller and its phase timer.
// The master (the controller) drives the phase code, the door switch and the raw
// level sensor. The slave (the timer) returns the phase-complete pulse, the
// debounced water level, the fill timeout flag, busy and the remaining tick count.
//   state           master->slave  3      controller phase code
//   door_closed     master->slave  1      door switch, synchronous to clk
//   water_level_raw master->slave  1      raw level sensor, asynchronous
//   cycle_complete  slave->master  1      1-cycle pulse, timed phase finished
//   water_level     slave->master  1      debounced level
//   fill_timeout    slave->master  1      fill took too long
//   busy            slave->master  1      timer counting
//   remaining       slave->master  CNT_W  ticks left in the timed phase
interface wm_phase_timer_if #(
    parameter int unsigned CNT_W = 16
);
    logic [2:0]       state;
    logic             door_closed;
    logic             water_level_raw;
    logic             cycle_complete;
    logic             water_level;
    logic             fill_timeout;
    logic             busy;
    logic [CNT_W-1:0] remaining;

    modport master (
        output state,
        output door_closed,
        output water_level_raw,
        input  cycle_complete,
        input  water_level,
        input  fill_timeout,
        input  busy,
        input  remaining
    );

    modport slave (
        input  state,
        input  door_closed,
        input  water_level_raw,
        output cycle_complete,
        output water_level,
        output fill_timeout,
        output busy,
        output remaining
    );
endinterface

// File: rtl/wm_phase_timer.sv
// Timing and sensing front end for the washing-machine controller.
// Follows the controller's phase code, times wash/rinse/spin/drain with a prescaled
// tick counter and returns a one-cycle cycle_complete pulse when a timed phase ends.
// The door opening pauses the count. The raw water-level sensor is synchronised and
// debounced, and a fill that runs FILL_TMO ticks without water raises fill_timeout.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-low reset
//   bus  wm_phase_timer_if.slave (state, door_closed, water_level_raw in;
//        cycle_complete, water_level, fill_timeout, busy, remaining out; all
//        outputs registered)
module wm_phase_timer #(
    parameter int unsigned CLK_DIV     = 1000,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned WASH_TICKS  = 30,
    parameter int unsigned RINSE_TICKS = 20,
    parameter int unsigned SPIN_TICKS  = 15,
    parameter int unsigned DRAIN_TICKS = 10,
    parameter int unsigned FILL_TMO    = 50,
    parameter int unsigned DEB_CYCLES  = 8
) (
    input  logic            clk,
    input  logic            rst,
    wm_phase_timer_if.slave bus
);
    localparam int unsigned PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned DEB_W   = $clog2(DEB_CYCLES + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0]   FILL_LIMIT = CNT_W'(FILL_TMO);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_FILL  = 3'd1;
    localparam logic [2:0] PH_WASH  = 3'd2;
    localparam logic [2:0] PH_RINSE = 3'd3;
    localparam logic [2:0] PH_SPIN  = 3'd4;
    localparam logic [2:0] PH_DRAIN = 3'd5;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_RUN   = 2'd1,
        T_PAUSE = 2'd2,
        T_DONE  = 2'd3
    } timer_state_e;

    // Tick budget of a phase; zero for untimed phases.
    function automatic logic [CNT_W-1:0] duration(input logic [2:0] ph);
        case (ph)
            PH_WASH:  duration = CNT_W'(WASH_TICKS);
            PH_RINSE: duration = CNT_W'(RINSE_TICKS);
            PH_SPIN:  duration = CNT_W'(SPIN_TICKS);
            PH_DRAIN: duration = CNT_W'(DRAIN_TICKS);
            default:  duration = '0;
        endcase
    endfunction

    function automatic logic is_timed(input logic [2:0] ph);
        is_timed = (ph == PH_WASH) || (ph == PH_RINSE) ||
                   (ph == PH_SPIN) || (ph == PH_DRAIN);
    endfunction

    timer_state_e       timer_q, timer_d;
    logic [2:0]         phase_q, phase_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
    logic               cc_q, cc_d;
    logic               fill_tmo_q, fill_tmo_d;
    logic               busy_q, busy_d;

    logic [1:0]         sync_q;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic               water_level_q, water_level_d;

    logic               phase_change;
    logic               in_fill;
    logic               presc_wrap;
    logic               tick;
    logic               fill_tick;
    logic [CNT_W-1:0]   new_dur;

    assign phase_change = (bus.state != phase_q);
    assign in_fill      = (phase_q == PH_FILL);
    assign presc_wrap   = (presc_q == PRESC_LAST);
    assign tick         = (timer_q == T_RUN) && presc_wrap;
    assign fill_tick    = in_fill && presc_wrap;
    assign new_dur      = duration(bus.state);

    // Phase timer state and its registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer_q     <= T_IDLE;
            phase_q     <= PH_IDLE;
            presc_q     <= '0;
            remaining_q <= '0;
            fill_cnt_q  <= '0;
            cc_q        <= 1'b0;
            fill_tmo_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            phase_q     <= phase_d;
            presc_q     <= presc_d;
            remaining_q <= remaining_d;
            fill_cnt_q  <= fill_cnt_d;
            cc_q        <= cc_d;
            fill_tmo_q  <= fill_tmo_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic for the phase timer and fill supervision.
    always_comb begin
        timer_d     = timer_q;
        phase_d     = phase_q;
        presc_d     = presc_q;
        remaining_d = remaining_q;
        fill_cnt_d  = fill_cnt_q;
        fill_tmo_d  = fill_tmo_q;
        cc_d        = 1'b0;

        if (phase_change) begin
            // A phase change restarts everything and drops any pulse in flight.
            phase_d     = bus.state;
            presc_d     = '0;
            remaining_d = new_dur;
            fill_cnt_d  = '0;
            fill_tmo_d  = 1'b0;
            if (!is_timed(bus.state)) begin
                timer_d = T_IDLE;
            end else if (new_dur == '0) begin
                cc_d    = 1'b1;
                timer_d = T_DONE;
            end else begin
                timer_d = T_RUN;
            end
        end else begin
            // The prescaler runs while timing a phase or supervising a fill.
            if ((timer_q == T_RUN) || in_fill) begin
                presc_d = presc_wrap ? '0 : presc_q + 1'b1;
            end

            case (timer_q)
                T_RUN: begin
                    if (tick && (remaining_q != '0)) begin
                        remaining_d = remaining_q - 1'b1;
                    end
                    if (tick && (remaining_q == CNT_W'(1))) begin
                        cc_d    = 1'b1;
                        timer_d = T_DONE;
                    end else if (!bus.door_closed) begin
                        timer_d = T_PAUSE;
                    end
                end
                T_PAUSE: begin
                    if (bus.door_closed) begin
                        timer_d = T_RUN;
                    end
                end
                default: begin
                    timer_d = timer_q;
                end
            endcase

            if (in_fill) begin
                if (water_level_q) begin
                    fill_cnt_d = '0;
                end else begin
                    if (fill_tick && (fill_cnt_q != CNT_MAX)) begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                    end
                    if (fill_cnt_d >= FILL_LIMIT) begin
                        fill_tmo_d = 1'b1;
                    end
                end
            end
        end

        busy_d = (timer_d == T_RUN);
    end

    // Two-flop synchroniser for the asynchronous level sensor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bus.water_level_raw};
        end
    end

    // Debounce state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_cnt_q     <= '0;
            water_level_q <= 1'b0;
        end else begin
            deb_cnt_q     <= deb_cnt_d;
            water_level_q <= water_level_d;
        end
    end

    // Toggle the level after DEB_CYCLES consecutive differing samples.
    always_comb begin
        deb_cnt_d     = '0;
        water_level_d = water_level_q;
        if (sync_q[1] != water_level_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                water_level_d = ~water_level_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    assign bus.cycle_complete = cc_q;
    assign bus.water_level    = water_level_q;
    assign bus.fill_timeout   = fill_tmo_q;
    assign bus.busy           = busy_q;
    assign bus.remaining      = remaining_q;
endmodule

// File: tb/tb_wm_phase_timer.sv
// Self-checking bench for wm_phase_timer with CLK_DIV=4, WASH=3, RINSE=2, SPIN=1,
// DRAIN=0, FILL_TMO=2, DEB_CYCLES=8. Cycle 0 of each sequence is the first cycle
// in which the new input values are presented.
module tb_wm_phase_timer;
    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wm_phase_timer_if #(.CNT_W(CNT_W)) bus ();

    wm_phase_timer #(
        .CLK_DIV    (4),
        .CNT_W      (CNT_W),
        .WASH_TICKS (3),
        .RINSE_TICKS(2),
        .SPIN_TICKS (1),
        .DRAIN_TICKS(0),
        .FILL_TMO   (2),
        .DEB_CYCLES (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [2:0] to_state;
        int         door_lo_start;
        int         door_lo_end;
        int         abort_cycle;
        logic [2:0] abort_state;
        int         exp_pulse;
        int         chk_cycle;
        int         exp_rem;
        logic       exp_busy;
        int         ncycles;
    } vec_t;

    vec_t vecs[8];
    int   exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle_idle();
        bus.state       = 3'd0;
        bus.door_closed = 1'b1;
        repeat (3) next_cycle();
    endtask

    task automatic run_vector(input int idx);
        vec_t v;
        int   got;
        v = vecs[idx];
        settle_idle();
        if (v.exp_pulse >= 0) exp_q.push_back(v.exp_pulse);
        for (int c = 0; c < v.ncycles; c++) begin
            if (c == 0) bus.state = v.to_state;
            if (c == v.abort_cycle) bus.state = v.abort_state;
            bus.door_closed = !((c >= v.door_lo_start) && (c <= v.door_lo_end));
            @(negedge clk);
            if (bus.cycle_complete) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("v%0d unexpected pulse cycle", idx), c, -1);
                end else begin
                    got = exp_q.pop_front();
                    check($sformatf("v%0d pulse cycle", idx), c, got);
                end
            end
            if (c == v.chk_cycle) begin
                check($sformatf("v%0d remaining@%0d", idx, c), int'(bus.remaining), v.exp_rem);
                check($sformatf("v%0d busy@%0d", idx, c), int'(bus.busy), int'(v.exp_busy));
            end
            next_cycle();
        end
        check($sformatf("v%0d missing pulses", idx), exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int first;
        int cnt;

        //          to    dlo  dhi  abt  abst  pulse chk rem busy n
        vecs[0] = '{3'd2, -1,  -2,  -1,  3'd0, 13,   1,  3,  1'b1, 20};
        vecs[1] = '{3'd2,  5,   9,  -1,  3'd0, 18,   8,  2,  1'b0, 25};
        vecs[2] = '{3'd2, -1,  -2,   6,  3'd7, -1,   7,  0,  1'b0, 20};
        vecs[3] = '{3'd5, -1,  -2,  -1,  3'd0,  1,   2,  0,  1'b0,  8};
        vecs[4] = '{3'd3, -1,  -2,  -1,  3'd0,  9,   5,  1,  1'b1, 14};
        vecs[5] = '{3'd4, -1,  -2,  -1,  3'd0,  5,   3,  1,  1'b1, 10};
        vecs[6] = '{3'd6, -1,  -2,  -1,  3'd0, -1,   3,  0,  1'b0,  8};
        vecs[7] = '{3'd4,  2,   3,  -1,  3'd0,  7,   4,  1,  1'b0, 12};

        rst                 = 1'b0;
        bus.state           = 3'd0;
        bus.door_closed     = 1'b1;
        bus.water_level_raw = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset cycle_complete", int'(bus.cycle_complete), 0);
        check("reset water_level", int'(bus.water_level), 0);
        check("reset fill_timeout", int'(bus.fill_timeout), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset remaining", int'(bus.remaining), 0);
        next_cycle();
        rst = 1'b1;

        for (int i = 0; i < 8; i++) run_vector(i);

        // Fill without water: timeout from cycle 9, sticky, cleared by leaving fill.
        settle_idle();
        first = -1;
        for (int c = 0; c < 20; c++) begin
            if (c == 0) bus.state = 3'd1;
            if (c == 14) bus.state = 3'd2;
            @(negedge clk);
            if (bus.fill_timeout && (first < 0)) first = c;
            if (c == 13) check("fill_timeout sticky", int'(bus.fill_timeout), 1);
            if (c == 15) check("fill_timeout cleared", int'(bus.fill_timeout), 0);
            next_cycle();
        end
        check("fill_timeout first cycle", first, 9);

        // Level glitch of 5 cycles must be rejected.
        settle_idle();
        cnt = 0;
        for (int c = 0; c < 25; c++) begin
            bus.water_level_raw = (c < 5);
            @(negedge clk);
            if (bus.water_level) cnt++;
            next_cycle();
        end
        check("glitch level cycles", cnt, 0);

        // Clean rise appears at cycle DEB_CYCLES+2.
        first = -1;
        for (int c = 0; c < 20; c++) begin
            bus.water_level_raw = 1'b1;
            @(negedge clk);
            if (bus.water_level && (first < 0)) first = c;
            next_cycle();
        end
        check("level rise cycle", first, 10);

        // Fill with water present never times out.
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 0) bus.state = 3'd1;
            @(negedge clk);
            if (bus.fill_timeout) cnt++;
            next_cycle();
        end
        check("fill with water timeout cycles", cnt, 0);

        // Reset in the middle of a wash clears everything at once.
        settle_idle();
        bus.water_level_raw = 1'b0;
        bus.state = 3'd2;
        repeat (6) next_cycle();
        #2;
        rst = 1'b0;
        #1;
        check("midreset remaining", int'(bus.remaining), 0);
        check("midreset busy", int'(bus.busy), 0);
        check("midreset water_level", int'(bus.water_level), 0);
        check("midreset cycle_complete", int'(bus.cycle_complete), 0);
        bus.state = 3'd0;
        repeat (2) next_cycle();
        rst = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.cycle_complete) cnt++;
            next_cycle();
        end
        check("post reset pulses", cnt, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
